// File: rtl/ctrl_unit_4bit.sv
// Two-cycle FETCH/EXEC instruction sequencer driving the 4-bit datapath control word.
// Optional feature: define CTRL_SINGLE_STEP_EN to add step_req and a PAUSE state after each EXEC.
module ctrl_unit_4bit #(
    parameter int unsigned PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                step_req,
`endif
    output logic [PC_WIDTH-1:0] inst_addr,
    input  logic [15:0]         inst_data,
    input  logic                V,
    input  logic                C,
    input  logic                N,
    input  logic                Z,
    output logic                load_enable,
    output logic [1:0]          A_select,
    output logic [1:0]          B_select,
    output logic [1:0]          D_select,
    output logic [3:0]          G_select,
    output logic [1:0]          H_select,
    output logic                MB_select,
    output logic                MF_select,
    output logic                MD_select,
    output logic [3:0]          constant_input,
    output logic [3:0]          flags,
    output logic                halted
);

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalt,
        StPause
    } state_e;

    typedef struct packed {
        logic       load;
        logic [1:0] da;
        logic [1:0] aa;
        logic [1:0] ba;
        logic [3:0] g;
        logic [1:0] h;
        logic       mb;
        logic       mf;
        logic       md;
        logic [3:0] k;
    } ctrl_t;

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [15:0]         ir_q;
    logic [3:0]          flags_q;
    logic                halted_q;
    ctrl_t               ctrl_q;
    ctrl_t               ctrl_d;

    logic [3:0]          exec_op;
    logic                cond_met;
    logic                branch_taken;
    logic                latch_flags;
    logic [PC_WIDTH-1:0] pc_next;
    logic                unused_bits;

    assign unused_bits = ^{ir_q, inst_data[5:4]};

    // The control word is decoded from the ROM word during FETCH and registered alongside IR,
    // so EXEC outputs come straight from flops and clear asynchronously with reset.
    always_comb begin
        ctrl_d    = '0;
        ctrl_d.da = inst_data[11:10];
        ctrl_d.aa = inst_data[9:8];
        ctrl_d.ba = inst_data[7:6];
        case (inst_data[15:12])
            4'h1: begin ctrl_d.load = 1'b1; ctrl_d.g = 4'b0000; end
            4'h2: begin ctrl_d.load = 1'b1; ctrl_d.g = 4'b0001; end
            4'h3: begin ctrl_d.load = 1'b1; ctrl_d.g = 4'b0010; end
            4'h4: begin ctrl_d.load = 1'b1; ctrl_d.g = 4'b0101; end
            4'h5: begin ctrl_d.load = 1'b1; ctrl_d.g = 4'b0110; end
            4'h6: begin ctrl_d.load = 1'b1; ctrl_d.g = 4'b1000; end
            4'h7: begin ctrl_d.load = 1'b1; ctrl_d.g = 4'b1010; end
            4'h8: begin ctrl_d.load = 1'b1; ctrl_d.g = 4'b1100; end
            4'h9: begin ctrl_d.load = 1'b1; ctrl_d.g = 4'b1110; end
            4'hA: begin ctrl_d.load = 1'b1; ctrl_d.mf = 1'b1; ctrl_d.h = 2'b01; end
            4'hB: begin ctrl_d.load = 1'b1; ctrl_d.mf = 1'b1; ctrl_d.h = 2'b10; end
            4'hC: begin
                ctrl_d.load = 1'b1;
                ctrl_d.mb   = 1'b1;
                ctrl_d.mf   = 1'b1;
                ctrl_d.h    = 2'b00;
                ctrl_d.k    = inst_data[3:0];
            end
            4'hD: begin ctrl_d.load = 1'b1; ctrl_d.md = 1'b1; end
            default: ;
        endcase
    end

    // Branches resolve against latched flags {V,C,N,Z}, never the live status inputs.
    always_comb begin
        exec_op = ir_q[15:12];
        unique case (ir_q[11:10])
            2'b00: cond_met = 1'b1;
            2'b01: cond_met = flags_q[0];
            2'b10: cond_met = flags_q[1];
            2'b11: cond_met = flags_q[2];
            default: cond_met = 1'b0;
        endcase
        branch_taken = (exec_op == 4'hE) && cond_met;
        latch_flags  = (exec_op >= 4'h1) && (exec_op <= 4'h9);
        pc_next      = branch_taken ? ir_q[PC_WIDTH-1:0] : pc_q + PC_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StFetch;
            pc_q     <= '0;
            ir_q     <= '0;
            flags_q  <= '0;
            halted_q <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    ir_q    <= inst_data;
                    ctrl_q  <= ctrl_d;
                    state_q <= StExec;
                end
                StExec: begin
                    ctrl_q <= '0;
                    pc_q   <= pc_next;
                    if (latch_flags) begin
                        flags_q <= {V, C, N, Z};
                    end
                    if (exec_op == 4'hF) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else begin
`ifdef CTRL_SINGLE_STEP_EN
                        state_q <= StPause;
`else
                        state_q <= StFetch;
`endif
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                StPause: begin
`ifdef CTRL_SINGLE_STEP_EN
                    if (step_req) begin
                        state_q <= StFetch;
                    end
`else
                    state_q <= StFetch;
`endif
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign inst_addr      = pc_q;
    assign load_enable    = ctrl_q.load;
    assign D_select       = ctrl_q.da;
    assign A_select       = ctrl_q.aa;
    assign B_select       = ctrl_q.ba;
    assign G_select       = ctrl_q.g;
    assign H_select       = ctrl_q.h;
    assign MB_select      = ctrl_q.mb;
    assign MF_select      = ctrl_q.mf;
    assign MD_select      = ctrl_q.md;
    assign constant_input = ctrl_q.k;
    assign flags          = flags_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_ctrl_unit_4bit.sv
// Scoreboard bench for ctrl_unit_4bit: expectations queued per scenario, popped at each sample point.
module tb_ctrl_unit_4bit;
    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] inst_addr;
    logic [15:0]   inst_data;
    logic [3:0]    status = 4'h0;
    logic          load_enable, MB_select, MF_select, MD_select, halted;
    logic [1:0]    A_select, B_select, D_select, H_select;
    logic [3:0]    G_select, constant_input, flags;
    logic [15:0]   rom [16];
`ifdef CTRL_SINGLE_STEP_EN
    logic          step_req = 1'b0;
`endif

    ctrl_unit_4bit #(.PC_WIDTH(PW)) dut (
        .clk(clk),
        .reset(reset),
`ifdef CTRL_SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .inst_addr(inst_addr),
        .inst_data(inst_data),
        .V(status[3]),
        .C(status[2]),
        .N(status[1]),
        .Z(status[0]),
        .load_enable(load_enable),
        .A_select(A_select),
        .B_select(B_select),
        .D_select(D_select),
        .G_select(G_select),
        .H_select(H_select),
        .MB_select(MB_select),
        .MF_select(MF_select),
        .MD_select(MD_select),
        .constant_input(constant_input),
        .flags(flags),
        .halted(halted)
    );

    assign inst_data = rom[inst_addr];
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_underflow: got %0h, expected nothing", obs);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [31:0] mk_cw(input logic ld, input logic [1:0] d, input logic [1:0] a,
                                          input logic [1:0] b, input logic [3:0] g,
                                          input logic [1:0] h, input logic mb, input logic mf,
                                          input logic md, input logic [3:0] k);
        return {12'd0, ld, d, a, b, g, h, mb, mf, md, k};
    endfunction

    function automatic logic [31:0] cw_obs();
        return {12'd0, load_enable, D_select, A_select, B_select, G_select, H_select,
                MB_select, MF_select, MD_select, constant_input};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic load_prog1();
        clear_rom();
        rom[0] = 16'hC403;  // LDI R1,3
        rom[1] = 16'hC805;  // LDI R2,5
        rom[2] = 16'h3D80;  // ADD R3,R1,R2
    endtask

    task automatic run_branch(input logic z_at_sub, input logic [31:0] exp_addr);
        clear_rom();
        rom[3] = 16'h4140;  // SUB R0,R1,R1
        rom[4] = 16'hE407;  // BR Z -> 7
        push("sub_cw", mk_cw(1, 0, 1, 1, 4'b0101, 0, 0, 0, 0, 0));
        push("sub_flags", {31'd0, z_at_sub});
        push("br_load", 0);
        push("br_target", exp_addr);
        status = 4'h0;
        do_reset();
        cyc(7);
        pop_check(cw_obs());
        status = {3'b000, z_at_sub};
        cyc(1);
        pop_check({28'd0, flags});
        status = {3'b000, ~z_at_sub};
        cyc(1);
        pop_check({31'd0, load_enable});
        cyc(1);
        pop_check({28'd0, inst_addr});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        load_prog1();
        status = 4'hF;
        reset  = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
        push("rst_addr", 0);
        push("ss_pause_addr", 1);
        push("ss_pause_cw", 0);
        push("ss_hold_addr", 1);
        push("ss_step_cw", mk_cw(1, 2, 0, 0, 0, 0, 1, 1, 0, 5));
        push("ss_after_addr", 2);
        cyc(1);
        pop_check({28'd0, inst_addr});
        reset = 1'b0;
        cyc(2);
        pop_check({28'd0, inst_addr});
        pop_check(cw_obs());
        cyc(5);
        pop_check({28'd0, inst_addr});
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0;
        cyc(1);
        pop_check(cw_obs());
        cyc(4);
        pop_check({28'd0, inst_addr});
`else
        // Straight-line program, flag latching rules, and PC wrap.
        push("rst_addr", 0);
        push("rst_cw", 0);
        push("rst_flags", 0);
        push("rst_halted", 0);
        push("fetch0_cw", 0);
        push("ldi1_cw", mk_cw(1, 1, 0, 0, 0, 0, 1, 1, 0, 3));
        push("fetch1_addr", 1);
        push("ldi_keeps_flags", 0);
        push("ldi2_cw", mk_cw(1, 2, 0, 0, 0, 0, 1, 1, 0, 5));
        push("fetch2_addr", 2);
        push("add_cw", mk_cw(1, 3, 1, 2, 4'b0010, 0, 0, 0, 0, 0));
        push("pc_after_6", 3);
        push("add_flags", 4'b0110);
        push("nop_cw", 0);
        push("nop_keeps_flags", 4'b0110);
        push("pc_15", 15);
        push("pc_wrap", 0);
        push("wrap_halted", 0);
        cyc(1);
        pop_check({28'd0, inst_addr});
        pop_check(cw_obs());
        pop_check({28'd0, flags});
        pop_check({31'd0, halted});
        reset = 1'b0;
        pop_check(cw_obs());
        cyc(1);
        pop_check(cw_obs());
        cyc(1);
        pop_check({28'd0, inst_addr});
        pop_check({28'd0, flags});
        cyc(1);
        pop_check(cw_obs());
        cyc(1);
        pop_check({28'd0, inst_addr});
        cyc(1);
        pop_check(cw_obs());
        status = 4'b0110;
        cyc(1);
        pop_check({28'd0, inst_addr});
        pop_check({28'd0, flags});
        cyc(1);
        pop_check(cw_obs());
        status = 4'b1001;
        cyc(1);
        pop_check({28'd0, flags});
        cyc(22);
        pop_check({28'd0, inst_addr});
        cyc(2);
        pop_check({28'd0, inst_addr});
        pop_check({31'd0, halted});

        // Reset in the middle of ADD's EXEC drops the write strobe immediately.
        push("add_load_pre", 1);
        push("rst_async_load", 0);
        push("rst_async_cw", 0);
        push("rst_rel_addr", 0);
        push("rst_rel_flags", 0);
        push("rst_rel_next_addr", 1);
        load_prog1();
        status = 4'b1111;
        do_reset();
        cyc(5);
        pop_check({31'd0, load_enable});
        #2 reset = 1'b1;
        #1;
        pop_check({31'd0, load_enable});
        pop_check(cw_obs());
        @(negedge clk);
        reset = 1'b0;
        pop_check({28'd0, inst_addr});
        pop_check({28'd0, flags});
        cyc(2);
        pop_check({28'd0, inst_addr});

        // Conditional branch on latched Z, taken and not taken.
        run_branch(1'b1, 7);
        run_branch(1'b0, 5);

        // Branch on C, then a branch to its own address.
        clear_rom();
        rom[0] = 16'h2000;  // INC R0,R0
        rom[1] = 16'hEC09;  // BR C -> 9
        rom[9] = 16'hE009;  // BR always -> 9
        push("inc_cw", mk_cw(1, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0));
        push("brc_target", 9);
        push("tight_loop_1", 9);
        push("tight_loop_2", 9);
        status = 4'b0100;
        do_reset();
        cyc(1);
        pop_check(cw_obs());
        cyc(1);
        status = 4'b0000;
        cyc(2);
        pop_check({28'd0, inst_addr});
        cyc(2);
        pop_check({28'd0, inst_addr});
        cyc(2);
        pop_check({28'd0, inst_addr});

        // HALT at address 2 is absorbing.
        clear_rom();
        rom[2] = 16'hF000;
        for (int i = 0; i < 10; i++) begin
            push("halt_halted", 1);
            push("halt_addr", 3);
            push("halt_load", 0);
        end
        do_reset();
        cyc(6);
        for (int i = 0; i < 10; i++) begin
            pop_check({31'd0, halted});
            pop_check({28'd0, inst_addr});
            pop_check({31'd0, load_enable});
            cyc(1);
        end
`endif
        check_eq("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
